// File: rtl/cart_mapper.sv
// cart_mapper: NES cartridge mapper front-end (NROM / UxROM / CNROM / AxROM).
//
// Snoops CPU writes to $8000-$FFFF and keeps one bank register. From it, it
// produces the banked PRG and CHR SDRAM byte addresses and the CIRAM_A10
// mirroring line. Runs in the clk2x domain. The raw cart strobes are
// asynchronous, so each one passes through a 2-FF synchronizer.
//
// Parameters:
//   PRG_BANK_W  PRG bank index width in 16 KiB units (2..8)
//   CHR_BANK_W  CHR bank index width in 8 KiB units  (1..8)
//
// Ports:
//   clk         system clock (clk2x)
//   rst_n       synchronous active-low reset
//   en          cart active; low while the loader owns the cart
//   mode        0 NROM, 1 UxROM, 2 CNROM, 3 AxROM; sampled only while en=0
//   mirror_cfg  fixed mirroring for modes 0-2 (0 vertical/A10, 1 horizontal/A11)
//   m2, romsel, cpu_rw   raw asynchronous cart strobes
//   cpu_addr    CPU A14..A0
//   cpu_data    CPU data bus (input)
//   rom_data    PRG byte currently driven onto the bus (used for bus conflicts)
//   ppu_addr    PPU A13..A0
//   prg_addr    PRG SDRAM byte address (registered)
//   chr_addr    CHR SDRAM byte address (registered)
//   ciram_a10   CIRAM A10 (registered)
//   bank        current bank register
//   wr_stb      one-cycle pulse per accepted register write
//
// Build option:
//   MAPPER_BUS_CONFLICT_EN  when defined, every captured write byte is
//                           cpu_data & rom_data (discrete-logic bus conflict).
module cart_mapper #(
    parameter int unsigned PRG_BANK_W = 4,
    parameter int unsigned CHR_BANK_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic                      mirror_cfg,
    input  logic                      m2,
    input  logic                      romsel,
    input  logic                      cpu_rw,
    input  logic [14:0]               cpu_addr,
    input  logic [7:0]                cpu_data,
    input  logic [7:0]                rom_data,
    input  logic [13:0]               ppu_addr,
    output logic [14+PRG_BANK_W-1:0]  prg_addr,
    output logic [13+CHR_BANK_W-1:0]  chr_addr,
    output logic                      ciram_a10,
    output logic [7:0]                bank,
    output logic                      wr_stb
);

    typedef enum logic [1:0] {
        ModeNrom  = 2'd0,
        ModeUxrom = 2'd1,
        ModeCnrom = 2'd2,
        ModeAxrom = 2'd3
    } mode_e;

    // [0] first sync stage, [1] synchronized value, [2] (m2 only) previous
    // synchronized value for edge detection.
    logic [2:0] m2_sync_q;
    logic [1:0] romsel_sync_q;
    logic [1:0] rw_sync_q;

    logic [7:0] wdata_q;
    logic [7:0] bank_q;
    logic       wr_stb_q;
    mode_e      mode_q;

    logic [14+PRG_BANK_W-1:0] prg_addr_q, prg_addr_d;
    logic [13+CHR_BANK_W-1:0] chr_addr_q, chr_addr_d;
    logic                     ciram_a10_q, ciram_a10_d;

    logic [PRG_BANK_W-1:0] prg_bank;
    logic [CHR_BANK_W-1:0] chr_bank;
    logic [7:0]            wdata_sample;
    logic                  m2_fall;
    logic                  write_hit;

    // PPU A13 only selects pattern vs. nametable space, which the bus decodes.
    logic unused_ppu_a13;
    assign unused_ppu_a13 = ppu_addr[13];

`ifdef MAPPER_BUS_CONFLICT_EN
    // The ROM drives the bus at the same time as the CPU; open-collector
    // style the zeros win.
    assign wdata_sample = cpu_data & rom_data;
`else
    logic unused_rom_data;
    assign unused_rom_data = ^rom_data;
    assign wdata_sample    = cpu_data;
`endif

    assign m2_fall   = m2_sync_q[2] & ~m2_sync_q[1];
    assign write_hit = m2_fall & ~romsel_sync_q[1] & ~rw_sync_q[1] & en;

    // Bank selection and mirroring per mapper mode.
    always_comb begin
        prg_bank    = {{(PRG_BANK_W-1){1'b0}}, cpu_addr[14]};
        chr_bank    = '0;
        ciram_a10_d = mirror_cfg ? ppu_addr[11] : ppu_addr[10];
        unique case (mode_q)
            ModeNrom: ;
            ModeUxrom: begin
                // $C000-$FFFF is hard-wired to the last bank.
                prg_bank = cpu_addr[14] ? {PRG_BANK_W{1'b1}} : bank_q[PRG_BANK_W-1:0];
            end
            ModeCnrom: begin
                chr_bank = bank_q[CHR_BANK_W-1:0];
            end
            ModeAxrom: begin
                // 32 KiB banking: A14 stays the low bit of the 16 KiB index.
                prg_bank    = {bank_q[PRG_BANK_W-2:0], cpu_addr[14]};
                ciram_a10_d = bank_q[4];
            end
            default: ;
        endcase
        prg_addr_d = {prg_bank, cpu_addr[13:0]};
        chr_addr_d = {chr_bank, ppu_addr[12:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m2_sync_q     <= 3'b000;
            romsel_sync_q <= 2'b11;
            rw_sync_q     <= 2'b11;
            wdata_q       <= 8'h00;
            bank_q        <= 8'h00;
            wr_stb_q      <= 1'b0;
            mode_q        <= ModeNrom;
            prg_addr_q    <= '0;
            chr_addr_q    <= '0;
            ciram_a10_q   <= 1'b0;
        end else begin
            m2_sync_q     <= {m2_sync_q[1:0], m2};
            romsel_sync_q <= {romsel_sync_q[0], romsel};
            rw_sync_q     <= {rw_sync_q[0], cpu_rw};

            // Last sample taken while M2 is high is the written byte.
            if (m2_sync_q[1] && !romsel_sync_q[1]) begin
                wdata_q <= wdata_sample;
            end

            wr_stb_q <= write_hit;

            // en=0 overrides any write landing in the same cycle.
            if (!en) begin
                bank_q <= 8'h00;
                mode_q <= mode_e'(mode);
            end else if (write_hit) begin
                bank_q <= wdata_q;
            end

            prg_addr_q  <= prg_addr_d;
            chr_addr_q  <= chr_addr_d;
            ciram_a10_q <= ciram_a10_d;
        end
    end

    assign prg_addr  = prg_addr_q;
    assign chr_addr  = chr_addr_q;
    assign ciram_a10 = ciram_a10_q;
    assign bank      = bank_q;
    assign wr_stb    = wr_stb_q;

endmodule
